// File: rtl/crc32_byte_feeder_if.sv
// Host word-write channel into the CRC32 byte feeder.
interface crc32_byte_feeder_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [1:0]  wr_nbytes;
  logic        wr_last;

  modport master (output wr_valid, wr_data, wr_nbytes, wr_last, input wr_ready);
  modport slave  (input wr_valid, wr_data, wr_nbytes, wr_last, output wr_ready);
endinterface

// File: rtl/crc32_byte_feeder.sv
// Word FIFO plus byte serializer feeding a byte-serial CRC32 engine.
// Closes each message with data_done and latches the engine's final CRC.
module crc32_byte_feeder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  crc32_byte_feeder_if.slave          wr,
  input  logic                        abort,
  output logic                        crc_trigger,
  output logic [7:0]                  crc_byte,
  output logic                        data_done,
  input  logic                        crc_busy,
  input  logic                        crc_finished,
  input  logic [31:0]                 crc_result_in,
  output logic [31:0]                 result,
  output logic                        result_valid,
  output logic                        msg_active,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic        last;
    logic [1:0]  nbytes;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level;
  logic          push, pop, full, empty;

  state_t        state;
  logic [31:0]   word;
  logic [2:0]    cnt;
  logic          last;
  logic          first;
  logic          fin, done_last, drain_done;

  assign full        = (level == (AW+1)'(FIFO_DEPTH));
  assign empty       = (level == '0);
  assign wr.wr_ready = !full && !abort;
  assign push        = wr.wr_valid && wr.wr_ready;
  assign pop         = (state == IDLE) && !empty && !abort;
  assign head        = mem[rptr];
  assign fifo_level  = level;

  assign crc_trigger = (state == ISSUE) && !crc_busy && !abort;
  assign crc_byte    = word[7:0];

  // Finished is ignored the cycle after a trigger: the engine is still
  // showing the previous byte's status then.
  assign fin        = (state == WAIT) && !first && crc_finished;
  assign done_last  = fin && (cnt == 3'd1) && last && !abort;
  // During a drain the engine is either still finishing its byte or idle
  // already (abort between bytes), so either condition closes it.
  assign drain_done = (state == DRAIN) && (crc_finished || !crc_busy);
  assign data_done  = done_last || drain_done;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= entry_t'({wr.wr_last, wr.wr_nbytes, wr.wr_data});
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      word         <= '0;
      cnt          <= '0;
      last         <= 1'b0;
      first        <= 1'b0;
      msg_active   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (crc_trigger) msg_active <= 1'b1;
      if (data_done)   msg_active <= 1'b0;

      if (abort && state != DRAIN) begin
        state <= msg_active ? DRAIN : IDLE;
      end else begin
        case (state)
          IDLE: if (pop) begin
            word  <= head.data;
            cnt   <= (head.nbytes == 2'd0) ? 3'd4 : {1'b0, head.nbytes};
            last  <= head.last;
            state <= ISSUE;
          end
          ISSUE: if (crc_trigger) begin
            first <= 1'b1;
            state <= WAIT;
          end
          WAIT: begin
            first <= 1'b0;
            if (fin) begin
              if (cnt != 3'd1) begin
                word  <= {8'h00, word[31:8]};
                cnt   <= cnt - 3'd1;
                state <= ISSUE;
              end else begin
                if (last) begin
                  result       <= crc_result_in;
                  result_valid <= 1'b1;
                end
                state <= IDLE;
              end
            end
          end
          DRAIN: if (drain_done) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_crc32_byte_feeder.sv
// Directed bench for crc32_byte_feeder with a cycle-timed CRC engine model.
module tb_crc32_byte_feeder;
  localparam int DEPTH = 4;
  localparam byte EV_T = 8'h54;
  localparam byte EV_D = 8'h44;

  logic        clk, rst, abort;
  logic        crc_trigger, data_done, result_valid, msg_active;
  logic [7:0]  crc_byte;
  logic [31:0] result, crc_result_in;
  logic [$clog2(DEPTH):0] fifo_level;

  logic        eng_busy, eng_fin;
  logic [31:0] eng_crc;
  int          eng_cnt;

  int checks = 0, errors = 0;
  int cyc = 0;
  int trig_cnt = 0, done_cnt = 0, rv_cnt = 0;
  int rv_cyc = 0, done_cyc = 0, fin_cyc = -1;
  int acc_cyc = 0;
  byte         trig_bytes[$];
  byte         ev[$];
  logic [31:0] rv_vals[$];

  crc32_byte_feeder_if ifc ();

  crc32_byte_feeder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr(ifc), .abort(abort),
    .crc_trigger(crc_trigger), .crc_byte(crc_byte), .data_done(data_done),
    .crc_busy(eng_busy), .crc_finished(eng_fin), .crc_result_in(crc_result_in),
    .result(result), .result_valid(result_valid), .msg_active(msg_active),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Engine: 9 busy cycles (byte XOR + 8 poly), then one finished cycle.
  assign crc_result_in = ~eng_crc;
  always @(posedge clk) begin
    if (rst) begin
      eng_crc <= 32'hFFFFFFFF; eng_busy <= 1'b0; eng_fin <= 1'b0; eng_cnt <= 0;
    end else begin
      eng_fin <= 1'b0;
      if (crc_trigger) begin
        eng_crc <= crc_step(eng_crc, crc_byte); eng_busy <= 1'b1; eng_cnt <= 9;
      end else if (eng_busy) begin
        if (eng_cnt == 1) begin eng_busy <= 1'b0; eng_fin <= 1'b1; end
        eng_cnt <= eng_cnt - 1;
      end
      if (data_done) eng_crc <= 32'hFFFFFFFF;
    end
  end

  always @(negedge clk) if (!rst) begin
    if (crc_trigger) begin trig_cnt++; trig_bytes.push_back(crc_byte); ev.push_back(EV_T); end
    if (data_done) begin done_cnt++; done_cyc = cyc; ev.push_back(EV_D); end
    if (eng_fin) fin_cyc = cyc;
    if (result_valid) begin rv_cnt++; rv_cyc = cyc; rv_vals.push_back(result); end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] d, input logic [1:0] n, input logic l);
    int t = 0;
    @(negedge clk);
    ifc.wr_valid = 1'b1; ifc.wr_data = d; ifc.wr_nbytes = n; ifc.wr_last = l;
    while (!ifc.wr_ready && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) check("put_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    acc_cyc = cyc;
    ifc.wr_valid = 1'b0;
  endtask

  task automatic wait_rv(input int target);
    int t = 0;
    while (rv_cnt < target && t < 3000) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    check("rv_count", 32'(rv_cnt), 32'(target));
  endtask

  initial begin
    int bt, bd, br, be, t;
    rst = 1'b1; abort = 1'b0;
    ifc.wr_valid = 1'b0; ifc.wr_data = '0; ifc.wr_nbytes = '0; ifc.wr_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst_result", result, 32'h0);
    check("rst_result_valid", {31'h0, result_valid}, 32'h0);
    check("rst_trigger", {31'h0, crc_trigger}, 32'h0);
    check("rst_data_done", {31'h0, data_done}, 32'h0);
    check("rst_msg_active", {31'h0, msg_active}, 32'h0);
    check("rst_fifo_level", 32'(fifo_level), 32'h0);
    check("rst_wr_ready", {31'h0, ifc.wr_ready}, 32'h1);

    // "123456789" over three words
    bt = trig_cnt; bd = done_cnt; br = rv_cnt;
    put(32'h34333231, 2'd0, 1'b0);
    put(32'h38373635, 2'd0, 1'b0);
    put(32'h00000039, 2'd1, 1'b1);
    check("msg_active_mid", {31'h0, msg_active}, 32'h1);
    wait_rv(br + 1);
    check("check_result", result, 32'hCBF43926);
    check("check_triggers", 32'(trig_cnt - bt), 32'd9);
    check("check_done", 32'(done_cnt - bd), 32'd1);
    check("msg_active_end", {31'h0, msg_active}, 32'h0);

    // "a" with latency, then a single zero byte
    br = rv_cnt;
    put(32'h00000061, 2'd1, 1'b1);
    wait_rv(br + 1);
    check("a_result", result, 32'hE8B7BE43);
    check("a_latency", 32'(rv_cyc - acc_cyc), 32'd12);
    put(32'h00000000, 2'd1, 1'b1);
    wait_rv(br + 2);
    check("zero_result", result, 32'hD202EF8D);

    // FIFO fill and backpressure, bytes 0..23 in order
    bt = trig_cnt; br = rv_cnt;
    for (int k = 0; k < 5; k++)
      put({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, 2'd0, 1'b0);
    @(negedge clk);
    check("fill_level", 32'(fifo_level), 32'd4);
    check("fill_ready_low", {31'h0, ifc.wr_ready}, 32'h0);
    put({8'd23, 8'd22, 8'd21, 8'd20}, 2'd0, 1'b1);
    check("fill_accept_after_pop", 32'(trig_cnt - bt), 32'd5);
    check("fill_level_after", 32'(fifo_level), 32'd4);
    wait_rv(br + 1);
    check("fill_triggers", 32'(trig_cnt - bt), 32'd24);
    for (int i = 0; i < 24; i++)
      check("fill_byte_order", {24'h0, trig_bytes[bt + i]}, 32'(i));

    // Back-to-back messages
    bt = trig_cnt; bd = done_cnt; br = rv_cnt; be = ev.size();
    put(32'h00000061, 2'd1, 1'b1);
    put(32'h34333231, 2'd0, 1'b0);
    put(32'h38373635, 2'd0, 1'b0);
    put(32'h00000039, 2'd1, 1'b1);
    wait_rv(br + 2);
    check("b2b_first", rv_vals[br], 32'hE8B7BE43);
    check("b2b_second", rv_vals[br + 1], 32'hCBF43926);
    check("b2b_ev0", {24'h0, ev[be]}, {24'h0, EV_T});
    check("b2b_ev1", {24'h0, ev[be + 1]}, {24'h0, EV_D});
    check("b2b_ev2", {24'h0, ev[be + 2]}, {24'h0, EV_T});
    check("b2b_triggers", 32'(trig_cnt - bt), 32'd10);
    check("b2b_done", 32'(done_cnt - bd), 32'd2);

    // Abort during the WAIT of byte 2
    bt = trig_cnt; bd = done_cnt; br = rv_cnt;
    put(32'h34333231, 2'd0, 1'b0);
    put(32'h38373635, 2'd0, 1'b0);
    put(32'h00000039, 2'd1, 1'b1);
    t = 0;
    while (trig_cnt < bt + 2 && t < 500) begin @(negedge clk); t++; end
    check("abort_reach_byte2", 32'(trig_cnt - bt), 32'd2);
    repeat (3) @(negedge clk);
    check("abort_level_before", 32'(fifo_level), 32'd2);
    abort = 1'b1; #1;
    check("abort_ready_low", {31'h0, ifc.wr_ready}, 32'h0);
    @(posedge clk); #1; abort = 1'b0;
    check("abort_level_cleared", 32'(fifo_level), 32'd0);
    check("abort_msg_active", {31'h0, msg_active}, 32'h1);
    repeat (20) @(negedge clk);
    check("abort_done", 32'(done_cnt - bd), 32'd1);
    check("abort_done_at_finish", 32'(done_cyc), 32'(fin_cyc));
    check("abort_no_rv", 32'(rv_cnt - br), 32'd0);
    check("abort_no_more_trig", 32'(trig_cnt - bt), 32'd2);
    check("abort_result_kept", result, 32'hCBF43926);
    check("abort_msg_closed", {31'h0, msg_active}, 32'h0);
    put(32'hDEADBE61, 2'd1, 1'b1);
    wait_rv(br + 1);
    check("after_abort_a", result, 32'hE8B7BE43);

    // Abort in IDLE with a write offered
    bt = trig_cnt; bd = done_cnt;
    @(negedge clk);
    ifc.wr_valid = 1'b1; ifc.wr_data = 32'h00000061; ifc.wr_nbytes = 2'd1; ifc.wr_last = 1'b1;
    abort = 1'b1; #1;
    check("idle_abort_ready", {31'h0, ifc.wr_ready}, 32'h0);
    @(posedge clk); #1;
    ifc.wr_valid = 1'b0; abort = 1'b0;
    repeat (15) @(negedge clk);
    check("idle_abort_level", 32'(fifo_level), 32'd0);
    check("idle_abort_trig", 32'(trig_cnt - bt), 32'd0);
    check("idle_abort_done", 32'(done_cnt - bd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/crc32_byte_feeder.md
Name: crc32_byte_feeder

Overview:
- Upstream stage of the CRC32 engine (reflected poly 0xEDB88320, init/xorout 0xFFFFFFFF).
- Accepts 32-bit words from the TinyQV peripheral register path into a small FIFO.
- Serializes them LSB-byte-first into the engine's trigger/byte handshake.
- Captures the final CRC before closing the message, and supports abort with a clean engine drain.

Parameters:
- FIFO_DEPTH, 4: word FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  host word valid
- wr_ready  out  1  word accepted when wr_valid&&wr_ready at posedge
- wr_data  in  32  message bytes, byte0=[7:0] sent first
- wr_nbytes  in  2  valid bytes in word, 0 means 4, 1..3 literal (low bytes)
- wr_last  in  1  word ends the message
- abort  in  1  flush FIFO, discard message in flight
- crc_trigger  out  1  engine: start one byte (single-cycle pulse)
- crc_byte  out  8  engine: byte, valid while crc_trigger=1
- data_done  out  1  engine: close message, return to init (single-cycle pulse)
- crc_busy  in  1  engine busy
- crc_finished  in  1  engine byte complete, result stable
- crc_result_in  in  32  engine final-XORed CRC
- result  out  32  last completed message CRC
- result_valid  out  1  one-cycle pulse when result updates
- msg_active  out  1  message in progress (first trigger to data_done)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset values:
  - outputs: result=0, result_valid=0, crc_trigger=0, data_done=0, msg_active=0, fifo_level=0.
  - state: FIFO empty, state IDLE.
  - wr_ready=1 in the cycle after reset deasserts.
- FIFO entry format: {last, nbytes, data} (35 bits).
- wr_ready = !full && !abort.
- Push and pop in the same cycle are both allowed. The level is unchanged.
- States:
  - IDLE: if FIFO non-empty, pop into the word register and load byte count (0→4). Go to ISSUE.
  - ISSUE:
    - crc_trigger=1 and crc_byte=word[7:0], only when crc_busy=0. Set msg_active.
    - Next cycle → WAIT.
    - If crc_busy=1, hold in ISSUE with trigger low.
  - WAIT: wait for crc_finished=1. The cycle immediately after a trigger never counts, because the engine is busy. On finished:
    - Bytes remain: shift word right 8 and decrement count. → ISSUE.
    - Word exhausted, not last: → IDLE (pop next word; message stays open, no data_done).
    - Word exhausted, last: capture result<=crc_result_in the same cycle and assert data_done=1. Next cycle result_valid=1 and msg_active=0. → IDLE.
  - DRAIN: wait for crc_finished=1, then data_done=1 → IDLE. No result update and no result_valid.
- Timing:
  - Per byte, ISSUE to next ISSUE is 11 cycles: 1 byte-XOR, 8 poly, 1 done, 1 feeder turnaround.
  - Single-byte message: result_valid is high in the cycle 12 edges after the accepting edge.
- abort:
  - Has priority over everything that cycle: FIFO cleared, crc_trigger suppressed, write refused.
  - If msg_active=1: → DRAIN. If no engine byte has been issued since the last data_done: → IDLE directly.
  - Ignored in DRAIN (stays DRAIN).
- Result register holds its value until the next completed message.
- Writes are accepted during any state, including DRAIN. Queued words start only after returning to IDLE.
- A message may span any number of words. Bytes above nbytes in a word are ignored.
- Reset mid-operation returns to IDLE with the FIFO empty. The engine is reset by the same rst.

Test Plan:
- Words 0x34333231/n0, 0x38373635/n0, 0x00000039/n1/last ("123456789") → result=0xCBF43926, one result_valid pulse, exactly 9 crc_trigger pulses and 1 data_done.
- Single word 0x00000061/n1/last ("a") → result=0xE8B7BE43; result_valid high 12 edges after acceptance. Then word 0x00000000/n1/last → result=0xD202EF8D.
- Fill FIFO with FIFO_DEPTH+1 back-to-back writes → wr_ready low when fifo_level=4; the 5th word is accepted after the first pop; all bytes are delivered in order.
- Back-to-back messages "a" then "123456789" queued together → two result_valid pulses with 0xE8B7BE43 then 0xCBF43926. data_done precedes the second message's first trigger.
- abort during WAIT of byte 2 of "123456789" → no result_valid, data_done after crc_finished, FIFO empty, result unchanged. Subsequent "a" → 0xE8B7BE43.
- abort asserted with wr_valid=1 in IDLE, empty FIFO → write refused, no trigger, no data_done, fifo_level=0.
